bullet_pool: RTL and testbench

//  Downstream of the tank block: owns every bullet one tank fires. Latches the tank's fire pulses and spawns bullets into a fixed slot pool.
//  On each game_tick it sweeps the pool: advances each bullet, queries the wall map, and retires bullets on boundary, wall or enemy contact.

---
 rtl/game_pkg.sv | 43 ++++
 rtl/bullet_pool_if.sv | 52 +++++
 rtl/bullet_step.sv | 40 ++++
 rtl/bullet_pool.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_bullet_pool.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared game definitions used by the bullet pool and its step unit:
//   - direction encoding (0 up, 1 down, 2 left, 3 right)
//   - play-area bounds and tank/bullet footprints in pixels
//   - bullet slot record and pool sweep FSM states
// No ports (package).
// ----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int AREA_MIN_X = 4;
  localparam int AREA_MIN_Y = 4;
  localparam int AREA_MAX_X = 194;
  localparam int AREA_MAX_Y = 138;
  localparam int TANK_W     = 3;
  localparam int TANK_H     = 4;
  localparam int BULLET_SZ  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_QUERY,
    ST_EVAL,
    ST_DONE
  } pool_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [7:0] y;
    dir_e       dir;
    logic       pierce;
    logic       fresh;
  } slot_t;

endpackage

// File: rtl/bullet_pool_if.sv
// ----------------------------------------------------------------------------
// bullet_pool_if
// Groups every non-clock/reset signal of the bullet pool.
//   slave  : the bullet pool's view (game/tank/map/VGA inputs, query outputs)
//   master : the surrounding game's view
// Signals:
//   game_tick, game_start              game step strobe / play enable
//   fire_bullet, fire_spread,
//   fire_pierce, start_x/y, start_dir  spawn request from the tank
//   enemy_x/y, enemy_alive             opposing tank position
//   wall_x/y (pool out), wall_hit (in) wall map query
//   hit_enemy                          1-clk hit pulse to opposing tank
//   pix_x/y, bullet_pix                VGA per-pixel query
//   active_cnt                         number of live slots
// ----------------------------------------------------------------------------
interface bullet_pool_if;

  logic       game_tick;
  logic       game_start;
  logic       fire_bullet;
  logic       fire_spread;
  logic       fire_pierce;
  logic [7:0] start_x;
  logic [7:0] start_y;
  logic [1:0] start_dir;
  logic [7:0] enemy_x;
  logic [7:0] enemy_y;
  logic       enemy_alive;
  logic [7:0] wall_x;
  logic [7:0] wall_y;
  logic       wall_hit;
  logic       hit_enemy;
  logic [7:0] pix_x;
  logic [7:0] pix_y;
  logic       bullet_pix;
  logic [4:0] active_cnt;

  modport master (
    output game_tick, game_start, fire_bullet, fire_spread, fire_pierce,
           start_x, start_y, start_dir, enemy_x, enemy_y, enemy_alive,
           wall_hit, pix_x, pix_y,
    input  wall_x, wall_y, hit_enemy, bullet_pix, active_cnt
  );

  modport slave (
    input  game_tick, game_start, fire_bullet, fire_spread, fire_pierce,
           start_x, start_y, start_dir, enemy_x, enemy_y, enemy_alive,
           wall_hit, pix_x, pix_y,
    output wall_x, wall_y, hit_enemy, bullet_pix, active_cnt
  );

endinterface

// File: rtl/bullet_step.sv
// ----------------------------------------------------------------------------
// bullet_step
// Combinational single-bullet motion step, shared by the whole pool sweep.
// Ports:
//   x_i, y_i   [7:0]  current bullet position
//   dir_i      dir_e  travel direction
//   speed_i    [7:0]  pixels per step
//   nx_o, ny_o [8:0]  next position; 9 bits so that moving past 0 shows up
//                     as a large value instead of wrapping into the field
//   oob_o             next position lies outside the play area
// ----------------------------------------------------------------------------
module bullet_step
  import game_pkg::*;
(
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  input  dir_e       dir_i,
  input  logic [7:0] speed_i,
  output logic [8:0] nx_o,
  output logic [8:0] ny_o,
  output logic       oob_o
);

  // Move along one axis only; an underflow wraps to >= 256 and is
  // therefore caught by the upper-bound comparisons.
  always_comb begin
    nx_o = {1'b0, x_i};
    ny_o = {1'b0, y_i};
    case (dir_i)
      DIR_UP:    ny_o = {1'b0, y_i} - {1'b0, speed_i};
      DIR_DOWN:  ny_o = {1'b0, y_i} + {1'b0, speed_i};
      DIR_LEFT:  nx_o = {1'b0, x_i} - {1'b0, speed_i};
      DIR_RIGHT: nx_o = {1'b0, x_i} + {1'b0, speed_i};
      default:   nx_o = {1'b0, x_i};
    endcase
    oob_o = (nx_o < 9'(AREA_MIN_X)) | (nx_o > 9'(AREA_MAX_X)) |
            (ny_o < 9'(AREA_MIN_Y)) | (ny_o > 9'(AREA_MAX_Y));
  end

endmodule

// File: rtl/bullet_pool.sv
// ----------------------------------------------------------------------------
// bullet_pool
// Owns every bullet one tank fires. Fire pulses are latched as a pending
// request; each game_tick runs one sweep that first spawns the pending
// bullets, then steps every live slot (query wall map, evaluate), and
// finally reports an enemy hit.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   bullet_pool_if.slave (tank fire, enemy position, wall map query,
//         hit_enemy pulse, VGA pixel query, active_cnt)
// Optional feature: define BULLET_LIFETIME_EN to give every bullet an age
// counter and expire it after LIFETIME steps.
// ----------------------------------------------------------------------------
module bullet_pool
  import game_pkg::*;
#(
  parameter int N_SLOTS       = 8,
  parameter int BULLET_SPEED  = 2,
  parameter int SPREAD_OFFSET = 3,
  parameter int LIFETIME      = 120
) (
  input  logic         clk,
  input  logic         rst,
  bullet_pool_if.slave bus
);

  localparam int IDX_W = $clog2(N_SLOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);

  pool_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       spawnCnt_q, spawnCnt_d;
  slot_t            slots_q [N_SLOTS];
  slot_t            slots_d [N_SLOTS];

  logic             pend_q, pend_d;
  logic             pendSpread_q, pendSpread_d;
  logic             pendPierce_q, pendPierce_d;
  logic [7:0]       pendX_q, pendX_d;
  logic [7:0]       pendY_q, pendY_d;
  dir_e             pendDir_q, pendDir_d;

  logic             hitFlag_q, hitFlag_d;
  logic             hitEnemy_q, hitEnemy_d;
  logic [7:0]       wallX_q, wallX_d;
  logic [7:0]       wallY_q, wallY_d;
  logic             bulletPix_q, bulletPix_d;
  logic [4:0]       activeCnt;

`ifdef BULLET_LIFETIME_EN
  localparam int AGE_W = $clog2(LIFETIME + 1);
  logic [AGE_W-1:0] age_q [N_SLOTS];
  logic [AGE_W-1:0] age_d [N_SLOTS];
`endif

  slot_t            cur;
  logic [8:0]       stepNx, stepNy;
  logic             stepOob;
  logic             freeFound;
  logic [IDX_W-1:0] freeIdx;
  logic [7:0]       spawnX, spawnY;
  logic             spawnLast, needEval, aged, freeNow, overlap, hitNow;
  logic             doSpawn, spawnExit, doQuery, doEval, doDone;

  assign cur = slots_q[idx_q];

  bullet_step u_step (
    .x_i     (cur.x),
    .y_i     (cur.y),
    .dir_i   (cur.dir),
    .speed_i (8'(BULLET_SPEED)),
    .nx_o    (stepNx),
    .ny_o    (stepNy),
    .oob_o   (stepOob)
  );

  // Lowest free slot; scanning downwards leaves the smallest index last.
  always_comb begin
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!slots_q[i].valid) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
    end
  end

  // Spawn position for the bullet currently being placed: centre, then
  // +offset, then -offset, offset perpendicular to the travel direction.
  always_comb begin
    spawnX = pendX_q;
    spawnY = pendY_q;
    if (spawnCnt_q != 2'd0) begin
      if (pendDir_q == DIR_UP || pendDir_q == DIR_DOWN) begin
        spawnX = (spawnCnt_q == 2'd1) ? pendX_q + 8'(SPREAD_OFFSET)
                                      : pendX_q - 8'(SPREAD_OFFSET);
      end else begin
        spawnY = (spawnCnt_q == 2'd1) ? pendY_q + 8'(SPREAD_OFFSET)
                                      : pendY_q - 8'(SPREAD_OFFSET);
      end
    end
    spawnLast = !freeFound || (spawnCnt_q == (pendSpread_q ? 2'd2 : 2'd0));
  end

  // Retirement rules for the slot being evaluated, in priority order:
  // age expiry, play-area bounds, wall (unless piercing), enemy overlap.
  always_comb begin
    needEval = cur.valid & ~cur.fresh;
`ifdef BULLET_LIFETIME_EN
    aged = (age_q[idx_q] == AGE_W'(LIFETIME - 1));
`else
    aged = 1'b0;
`endif
    overlap = bus.enemy_alive &
              (stepNx + 9'(BULLET_SZ - 1) >= {1'b0, bus.enemy_x}) &
              (stepNx <= {1'b0, bus.enemy_x} + 9'(TANK_W - 1)) &
              (stepNy + 9'(BULLET_SZ - 1) >= {1'b0, bus.enemy_y}) &
              (stepNy <= {1'b0, bus.enemy_y} + 9'(TANK_H - 1));
    freeNow = aged | stepOob | (bus.wall_hit & ~cur.pierce);
    hitNow  = ~freeNow & overlap;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; dropping game_start forces the sweep back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.game_tick) state_d = pend_q ? ST_SPAWN : ST_QUERY;
      ST_SPAWN: if (spawnLast) state_d = ST_QUERY;
      ST_QUERY: begin
        if (needEval)               state_d = ST_EVAL;
        else if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_EVAL:  state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_QUERY;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (!bus.game_start) state_d = ST_IDLE;
  end

  // FSM outputs: datapath strobes for the current state.
  always_comb begin
    doSpawn   = (state_q == ST_SPAWN) & freeFound;
    spawnExit = (state_q == ST_SPAWN) & spawnLast;
    doQuery   = (state_q == ST_QUERY) & needEval;
    doEval    = (state_q == ST_EVAL);
    doDone    = (state_q == ST_DONE);
  end

  // Slot storage and sweep bookkeeping.
  always_comb begin
    slots_d    = slots_q;
`ifdef BULLET_LIFETIME_EN
    age_d      = age_q;
`endif
    idx_d      = '0;
    spawnCnt_d = (state_q == ST_SPAWN) ? spawnCnt_q + 2'd1 : 2'd0;
    if (state_q == ST_EVAL || (state_q == ST_QUERY && !needEval)) begin
      idx_d = idx_q + 1'b1;
    end else if (state_q == ST_QUERY) begin
      idx_d = idx_q;
    end
    if (doSpawn) begin
      slots_d[freeIdx].valid  = 1'b1;
      slots_d[freeIdx].x      = spawnX;
      slots_d[freeIdx].y      = spawnY;
      slots_d[freeIdx].dir    = pendDir_q;
      slots_d[freeIdx].pierce = pendPierce_q;
      slots_d[freeIdx].fresh  = 1'b1;
`ifdef BULLET_LIFETIME_EN
      age_d[freeIdx] = '0;
`endif
    end
    if (doEval) begin
`ifdef BULLET_LIFETIME_EN
      age_d[idx_q] = age_q[idx_q] + 1'b1;
`endif
      if (freeNow || hitNow) begin
        slots_d[idx_q].valid = 1'b0;
      end else begin
        slots_d[idx_q].x = stepNx[7:0];
        slots_d[idx_q].y = stepNy[7:0];
      end
    end
    if (doDone) begin
      for (int i = 0; i < N_SLOTS; i++) slots_d[i].fresh = 1'b0;
    end
    if (!bus.game_start) begin
      for (int i = 0; i < N_SLOTS; i++) slots_d[i] = '0;
    end
  end

  // Pending fire request: only the first fire is kept until SPAWN consumes it.
  always_comb begin
    pend_d       = pend_q;
    pendSpread_d = pendSpread_q;
    pendPierce_d = pendPierce_q;
    pendX_d      = pendX_q;
    pendY_d      = pendY_q;
    pendDir_d    = pendDir_q;
    if (spawnExit) pend_d = 1'b0;
    if (bus.fire_bullet && !pend_q) begin
      pend_d       = 1'b1;
      pendSpread_d = bus.fire_spread;
      pendPierce_d = bus.fire_pierce;
      pendX_d      = bus.start_x;
      pendY_d      = bus.start_y;
      pendDir_d    = dir_e'(bus.start_dir);
    end
    if (!bus.game_start) pend_d = 1'b0;
  end

  // Wall query point, hit reporting and VGA pixel lookup.
  always_comb begin
    wallX_d    = doQuery ? stepNx[7:0] : wallX_q;
    wallY_d    = doQuery ? stepNy[7:0] : wallY_q;
    hitFlag_d  = doDone ? 1'b0 : (hitFlag_q | (doEval & hitNow));
    hitEnemy_d = doDone & hitFlag_q;
    if (!bus.game_start) begin
      hitFlag_d  = 1'b0;
      hitEnemy_d = 1'b0;
    end
    bulletPix_d = 1'b0;
    activeCnt   = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      activeCnt = activeCnt + 5'(slots_q[i].valid);
      if (slots_q[i].valid &&
          bus.pix_x >= slots_q[i].x &&
          {1'b0, bus.pix_x} <= {1'b0, slots_q[i].x} + 9'(BULLET_SZ - 1) &&
          bus.pix_y >= slots_q[i].y &&
          {1'b0, bus.pix_y} <= {1'b0, slots_q[i].y} + 9'(BULLET_SZ - 1)) begin
        bulletPix_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        slots_q[i] <= '0;
`ifdef BULLET_LIFETIME_EN
        age_q[i]   <= '0;
`endif
      end
      idx_q        <= '0;
      spawnCnt_q   <= '0;
      pend_q       <= 1'b0;
      pendSpread_q <= 1'b0;
      pendPierce_q <= 1'b0;
      pendX_q      <= '0;
      pendY_q      <= '0;
      pendDir_q    <= DIR_UP;
      hitFlag_q    <= 1'b0;
      hitEnemy_q   <= 1'b0;
      wallX_q      <= '0;
      wallY_q      <= '0;
      bulletPix_q  <= 1'b0;
    end else begin
      slots_q      <= slots_d;
`ifdef BULLET_LIFETIME_EN
      age_q        <= age_d;
`endif
      idx_q        <= idx_d;
      spawnCnt_q   <= spawnCnt_d;
      pend_q       <= pend_d;
      pendSpread_q <= pendSpread_d;
      pendPierce_q <= pendPierce_d;
      pendX_q      <= pendX_d;
      pendY_q      <= pendY_d;
      pendDir_q    <= pendDir_d;
      hitFlag_q    <= hitFlag_d;
      hitEnemy_q   <= hitEnemy_d;
      wallX_q      <= wallX_d;
      wallY_q      <= wallY_d;
      bulletPix_q  <= bulletPix_d;
    end
  end

  assign bus.wall_x     = wallX_q;
  assign bus.wall_y     = wallY_q;
  assign bus.hit_enemy  = hitEnemy_q;
  assign bus.bullet_pix = bulletPix_q;
  assign bus.active_cnt = activeCnt;

endmodule

// File: tb/tb_bullet_pool.sv
// ----------------------------------------------------------------------------
// tb_bullet_pool
// Directed bench for bullet_pool. Probes are issued by the stimulus thread
// (pixel query plus an expected value pushed into a queue); a monitor pops
// and compares when the registered response appears one clock later.
// ----------------------------------------------------------------------------
module tb_bullet_pool;
  import game_pkg::*;

  localparam int K_PIX    = 0;
  localparam int K_CNT    = 1;
  localparam int K_HITS   = 2;
  localparam int K_WX     = 3;
  localparam int K_WY     = 4;
  localparam int K_HITLVL = 5;
  localparam int SWEEP_WAIT = 26;
`ifdef BULLET_LIFETIME_EN
  localparam int TB_LIFETIME = 4;
`else
  localparam int TB_LIFETIME = 120;
`endif

  typedef struct {
    string name;
    int    kind;
    int    expv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wallOn = 1'b0;
  logic probeV = 1'b0;
  logic respV = 1'b0;
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   hitSeen = 0;

  always #5 clk = ~clk;

  bullet_pool_if bus();
  assign bus.wall_hit = wallOn;

  bullet_pool #(.N_SLOTS(8), .LIFETIME(TB_LIFETIME)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Response valid one clock after a probe, matching bullet_pix latency.
  always @(posedge clk) respV <= probeV;

  // Monitor: counts hit pulses and checks each probe response.
  always @(negedge clk) begin
    logic [31:0] actual;
    exp_t e;
    if (bus.hit_enemy === 1'b1) hitSeen++;
    if (respV) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_response: got a response, required none");
      end else begin
        e = sbq.pop_front();
        case (e.kind)
          K_PIX:    actual = 32'(bus.bullet_pix);
          K_CNT:    actual = 32'(bus.active_cnt);
          K_HITS:   begin actual = 32'(hitSeen); hitSeen = 0; end
          K_WX:     actual = 32'(bus.wall_x);
          K_WY:     actual = 32'(bus.wall_y);
          default:  actual = 32'(bus.hit_enemy);
        endcase
        if (actual !== 32'(e.expv)) begin
          errors++;
          $display("[TB] FAIL %s: actual=%0d required=%0d", e.name, actual, e.expv);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input int x, input int y, input int dir,
                               input bit spread, input bit pierce);
    @(negedge clk);
    bus.start_x     = 8'(x);
    bus.start_y     = 8'(y);
    bus.start_dir   = 2'(dir);
    bus.fire_spread = spread;
    bus.fire_pierce = pierce;
    bus.fire_bullet = 1'b1;
    @(negedge clk);
    bus.fire_bullet = 1'b0;
  endtask

  task automatic gameTick();
    @(negedge clk);
    bus.game_tick = 1'b1;
    @(negedge clk);
    bus.game_tick = 1'b0;
    repeat (SWEEP_WAIT) @(negedge clk);
  endtask

  task automatic clearPool();
    @(negedge clk);
    bus.game_start = 1'b0;
    @(negedge clk);
    bus.game_start = 1'b1;
  endtask

  task automatic checkOutput(input string name, input int kind,
                             input int px, input int py, input int expv);
    exp_t e;
    @(negedge clk);
    bus.pix_x = 8'(px);
    bus.pix_y = 8'(py);
    e.name = name;
    e.kind = kind;
    e.expv = expv;
    sbq.push_back(e);
    probeV = 1'b1;
    @(negedge clk);
    probeV = 1'b0;
  endtask

  initial begin
    bus.game_tick   = 1'b0;
    bus.game_start  = 1'b1;
    bus.fire_bullet = 1'b0;
    bus.fire_spread = 1'b0;
    bus.fire_pierce = 1'b0;
    bus.start_x     = '0;
    bus.start_y     = '0;
    bus.start_dir   = '0;
    bus.enemy_x     = 8'd10;
    bus.enemy_y     = 8'd10;
    bus.enemy_alive = 1'b0;
    bus.pix_x       = '0;
    bus.pix_y       = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_active_cnt", K_CNT, 0, 0, 0);
    checkOutput("rst_bullet_pix", K_PIX, 0, 0, 0);
    checkOutput("rst_wall_x", K_WX, 0, 0, 0);
    checkOutput("rst_hits", K_HITS, 0, 0, 0);

    $display("[TB] single bullet right");
    applyStimulus(50, 60, 3, 1'b0, 1'b0);
    gameTick();
    checkOutput("fresh_pix_50_60", K_PIX, 50, 60, 1);
    checkOutput("fresh_pix_51_61", K_PIX, 51, 61, 1);
    checkOutput("fresh_cnt", K_CNT, 0, 0, 1);
    gameTick();
    checkOutput("moved_pix_53_61", K_PIX, 53, 61, 1);
    checkOutput("moved_pix_51_60", K_PIX, 51, 60, 0);
    checkOutput("moved_cnt", K_CNT, 0, 0, 1);
    checkOutput("moved_wall_x", K_WX, 0, 0, 52);
    checkOutput("moved_wall_y", K_WY, 0, 0, 60);
    clearPool();
    checkOutput("game_start_clear_cnt", K_CNT, 0, 0, 0);

    $display("[TB] left boundary");
    bus.enemy_alive = 1'b1;
    applyStimulus(5, 60, 2, 1'b0, 1'b0);
    gameTick();
    checkOutput("edge_spawn_cnt", K_CNT, 0, 0, 1);
    gameTick();
    checkOutput("edge_freed_cnt", K_CNT, 0, 0, 0);
    checkOutput("edge_no_hit", K_HITS, 0, 0, 0);
    bus.enemy_alive = 1'b0;

    $display("[TB] spread up");
    applyStimulus(100, 100, 0, 1'b1, 1'b0);
    gameTick();
    checkOutput("spread_centre", K_PIX, 100, 100, 1);
    checkOutput("spread_plus", K_PIX, 103, 100, 1);
    checkOutput("spread_minus", K_PIX, 97, 100, 1);
    checkOutput("spread_gap", K_PIX, 99, 100, 0);
    checkOutput("spread_cnt", K_CNT, 0, 0, 3);
    clearPool();

    $display("[TB] walls");
    wallOn = 1'b1;
    applyStimulus(50, 60, 3, 1'b0, 1'b1);
    gameTick();
    gameTick();
    checkOutput("pierce_pix", K_PIX, 52, 60, 1);
    checkOutput("pierce_cnt", K_CNT, 0, 0, 1);
    clearPool();
    applyStimulus(50, 60, 3, 1'b0, 1'b0);
    gameTick();
    gameTick();
    checkOutput("wall_block_cnt", K_CNT, 0, 0, 0);
    wallOn = 1'b0;

    $display("[TB] enemy hits");
    bus.enemy_x     = 8'd60;
    bus.enemy_y     = 8'd60;
    bus.enemy_alive = 1'b1;
    applyStimulus(55, 61, 3, 1'b0, 1'b0);
    gameTick();
    gameTick();
    checkOutput("approach_no_hit", K_HITS, 0, 0, 0);
    gameTick();
    checkOutput("single_hit", K_HITS, 0, 0, 1);
    checkOutput("single_hit_cnt", K_CNT, 0, 0, 0);
    applyStimulus(59, 67, 0, 1'b1, 1'b0);
    gameTick();
    gameTick();
    gameTick();
    checkOutput("double_hit_one_pulse", K_HITS, 0, 0, 1);
    checkOutput("double_hit_cnt", K_CNT, 0, 0, 1);
    checkOutput("double_hit_survivor", K_PIX, 56, 63, 1);
    checkOutput("hit_pulse_low", K_HITLVL, 0, 0, 0);
    bus.enemy_alive = 1'b0;
    clearPool();

    $display("[TB] pool full");
    applyStimulus(20, 120, 0, 1'b1, 1'b0);
    gameTick();
    applyStimulus(60, 120, 0, 1'b1, 1'b0);
    gameTick();
    applyStimulus(140, 120, 0, 1'b1, 1'b0);
    gameTick();
    checkOutput("full_cnt", K_CNT, 0, 0, 8);
    checkOutput("full_dropped_minus", K_PIX, 137, 120, 0);
    checkOutput("full_plus_present", K_PIX, 143, 121, 1);
    checkOutput("full_first_group", K_PIX, 20, 116, 1);
    applyStimulus(180, 20, 3, 1'b0, 1'b0);
    gameTick();
    checkOutput("overfire_cnt", K_CNT, 0, 0, 8);
    checkOutput("overfire_not_spawned", K_PIX, 180, 20, 0);
    checkOutput("overfire_no_overwrite", K_PIX, 140, 118, 1);

    $display("[TB] reset mid-sweep");
    @(negedge clk);
    bus.game_tick = 1'b1;
    @(negedge clk);
    bus.game_tick = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_cnt", K_CNT, 0, 0, 0);
    checkOutput("midrst_pix", K_PIX, 140, 116, 0);
    checkOutput("midrst_wall_x", K_WX, 0, 0, 0);
    checkOutput("midrst_wall_y", K_WY, 0, 0, 0);
    checkOutput("midrst_hit", K_HITLVL, 0, 0, 0);
    repeat (SWEEP_WAIT) @(negedge clk);
    checkOutput("midrst_stays_idle", K_CNT, 0, 0, 0);

    $display("[TB] lifetime");
    applyStimulus(30, 30, 3, 1'b0, 1'b0);
    gameTick();
    gameTick();
    gameTick();
    gameTick();
    checkOutput("life_after_3_steps", K_PIX, 36, 30, 1);
    gameTick();
`ifdef BULLET_LIFETIME_EN
    checkOutput("life_expired_cnt", K_CNT, 0, 0, 0);
`else
    checkOutput("life_unlimited_cnt", K_CNT, 0, 0, 1);
    checkOutput("life_unlimited_pix", K_PIX, 38, 30, 1);
`endif

    repeat (4) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL missing_responses: actual=0 required=%0d", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
